// File: rtl/keypad_bcd_entry_if.sv
// Keypad and BCD display bundle between keypad_bcd_entry and its surroundings.
// master: the entry block (drives column strobes, key events and BCD digits).
// slave: the keypad matrix / consumer side (drives the active-low row lines).
interface keypad_bcd_entry_if;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       enter;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] units;

  modport master (
    input  row,
    output col, key_code, key_valid, enter, hundreds, tens, units
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, enter, hundreds, tens, units
  );
endinterface

// File: rtl/keypad_bcd_entry.sv
// 3x4 keypad scanner with debounce, feeding a 3-digit BCD shift register; '*' clears, '#' pulses enter.
// Key event appears two cycles after the column-2 sample of the deciding scan; no backpressure (events are pulses).
// HOLD_REPEAT_EN: when defined, a held digit re-fires every REPEAT_SCANS full scans after the first accept.
module keypad_bcd_entry #(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef HOLD_REPEAT_EN
  , parameter int REPEAT_SCANS = 167
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  keypad_bcd_entry_if.master  kp_if
);

  localparam int             PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam int             DB_W       = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_SCANS);
  localparam logic [3:0]     KEY_STAR   = 4'hA;
  localparam logic [3:0]     KEY_HASH   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED
  } state_t;

  // Key map: rows 0..2 hold digits 1..9 left to right, row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd2:    code = KEY_HASH;
        default: code = 4'h0;
      endcase
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  // Scanner state
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;   // keys seen so far this scan, saturating at 2
  logic [3:0]         acc_code_q, acc_code_d;
  logic               res_vld_q, res_vld_d;   // one-cycle strobe: a full-scan result is ready
  logic               res_none_q, res_none_d;
  logic [3:0]         res_code_q, res_code_d;

  logic [2:0]         col_hits;
  logic [3:0]         col_code;
  logic [2:0]         hits_total;
  logic [3:0]         code_sel;

  // Debounce FSM state
  state_t             state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [DB_W-1:0]    cnt_q, cnt_d;           // match count in DEBOUNCE, release count in PRESSED
  logic               accept;

`ifdef HOLD_REPEAT_EN
  localparam int              RPT_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_SCANS);
  logic [RPT_W-1:0]   rpt_q, rpt_d;
`endif

  // Output registers
  logic [3:0]         key_code_q;
  logic               key_valid_q;
  logic               enter_q;
  logic [3:0]         hundreds_q, tens_q, units_q;

  // Prescaler, column walk and per-scan accumulation of pressed keys.
  always_comb begin
    presc_d    = presc_q + PRESC_W'(1);
    col_idx_d  = col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    res_vld_d  = 1'b0;
    res_none_d = res_none_q;
    res_code_d = res_code_q;
    col_hits   = 3'd0;
    col_code   = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!kp_if.row[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_map(2'(r), col_idx_q);
      end
    end
    hits_total = {1'b0, acc_cnt_q} + col_hits;
    code_sel   = (col_hits == 3'd1) ? col_code : acc_code_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      if (col_idx_q == 2'd2) begin
        col_idx_d  = 2'd0;
        acc_cnt_d  = 2'd0;
        acc_code_d = 4'h0;
        res_vld_d  = 1'b1;
        res_none_d = (hits_total != 3'd1);
        res_code_d = code_sel;
      end else begin
        col_idx_d  = col_idx_q + 2'd1;
        acc_cnt_d  = (hits_total >= 3'd2) ? 2'd2 : hits_total[1:0];
        acc_code_d = code_sel;
      end
    end
  end

  // Scanner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      col_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'h0;
      res_vld_q  <= 1'b0;
      res_none_q <= 1'b1;
      res_code_q <= 4'h0;
    end else begin
      presc_q    <= presc_d;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
      res_vld_q  <= res_vld_d;
      res_none_q <= res_none_d;
      res_code_q <= res_code_d;
    end
  end

  // Debounce FSM next state: advances only on full-scan result strobes.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
`ifdef HOLD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (res_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (!res_none_q) begin
            cand_d = res_code_q;
            if (DB_LAST == DB_W'(1)) begin
              state_d = S_PRESSED;
              accept  = 1'b1;
              cnt_d   = '0;
`ifdef HOLD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = DB_W'(1);
            end
          end
        end
        S_DEBOUNCE: begin
          if (!res_none_q && (res_code_q == cand_q)) begin
            if ((cnt_q + DB_W'(1)) == DB_LAST) begin
              state_d = S_PRESSED;
              accept  = 1'b1;
              cnt_d   = '0;
`ifdef HOLD_REPEAT_EN
              rpt_d   = '0;
`endif
            end else begin
              cnt_d = cnt_q + DB_W'(1);
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED: begin
          if (res_none_q) begin
            if ((cnt_q + DB_W'(1)) == DB_LAST) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + DB_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
`ifdef HOLD_REPEAT_EN
          // Only the accepted digit, still held, advances the repeat timer.
          if (!res_none_q && (res_code_q == cand_q) && (cand_q <= 4'd9)) begin
            if ((rpt_q + RPT_W'(1)) == RPT_LAST) begin
              accept = 1'b1;
              rpt_d  = '0;
            end else begin
              rpt_d = rpt_q + RPT_W'(1);
            end
          end else begin
            rpt_d = '0;
          end
`endif
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cand_q  <= 4'h0;
      cnt_q   <= '0;
`ifdef HOLD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
`ifdef HOLD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  // Key event pulses and held key code.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      enter_q     <= 1'b0;
    end else begin
      key_valid_q <= accept;
      enter_q     <= accept && (cand_d == KEY_HASH);
      if (accept) begin
        key_code_q <= cand_d;
      end
    end
  end

  // BCD value: digits shift left on entry, '*' clears, '#' leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hundreds_q <= 4'h0;
      tens_q     <= 4'h0;
      units_q    <= 4'h0;
    end else if (accept) begin
      if (cand_d <= 4'd9) begin
        hundreds_q <= tens_q;
        tens_q     <= units_q;
        units_q    <= cand_d;
      end else if (cand_d == KEY_STAR) begin
        hundreds_q <= 4'h0;
        tens_q     <= 4'h0;
        units_q    <= 4'h0;
      end
    end
  end

  assign kp_if.col       = ~(3'b001 << col_idx_q);
  assign kp_if.key_code  = key_code_q;
  assign kp_if.key_valid = key_valid_q;
  assign kp_if.enter     = enter_q;
  assign kp_if.hundreds  = hundreds_q;
  assign kp_if.tens      = tens_q;
  assign kp_if.units     = units_q;

endmodule
